snake_tick_scheduler: RTL and testbench
=======================================

// Module: snake_tick_scheduler
// PURPOSE
//   Central timing controller for the Snake game. Replaces per-consumer derived clocks with
//   single-cycle enable strobes in the clk domain. Sequences game play (idle/run/pause/over),
//   generates the snake move strobe with a level-dependent speed and a free-running display
//   refresh strobe. Consumed by the snake-body logic, food/score logic and display scan.
// PARAMETERS
//   BASE_PERIOD     50_000_000  clk cycles per move at level 0
//   PERIOD_STEP     2_500_000   cycles removed from the move period per level
//   MIN_PERIOD      10_000_000  floor of the move period (must be >= 2)
//   FOODS_PER_LEVEL 4           food_eaten pulses per level increment
//   MAX_LEVEL       15          level saturates here (must fit in 4 bits)
//   REFRESH_DIV     5000        clk cycles per refresh_tick
//   CNT_W           32          width of internal counters
// PORTS
//   clk           in   1  system clock
//   rst_n         in   1  asynchronous reset, active low
//   start         in   1  1-cycle pulse: begin new game
//   pause_req     in   1  1-cycle pulse: toggle pause
//   game_over     in   1  1-cycle pulse: collision detected
//   food_eaten    in   1  1-cycle pulse: snake ate food
//   move_tick     out  1  1-cycle strobe: advance snake one cell
//   refresh_tick  out  1  1-cycle strobe: advance display scan
//   level         out  4  current speed level
//   state         out  2  0=IDLE 1=RUN 2=PAUSED 3=OVER
// BEHAVIOUR
//   - Reset (async assert, sync deassert by clk): state=IDLE, move_tick=0, refresh_tick=0,
//     level=0, all counters 0. All outputs registered.
//   - IDLE:   start -> RUN; move counter, food counter, level cleared.
//   - RUN:    move counter increments each cycle; when it reaches period-1 it wraps to 0 and
//             move_tick is 1 the next cycle. First move_tick exactly period cycles after the
//             edge that accepts start. game_over -> OVER; else pause_req -> PAUSED.
//   - PAUSED: counter holds value; no move_tick. pause_req -> RUN (count resumes from held
//             value). game_over -> OVER. start ignored.
//   - OVER:   no move_tick; level held for display. start -> RUN with clears as from IDLE.
//   - Priority in any state: game_over > pause_req > start. Ignored inputs have no effect.
//   - period = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD); compute in CNT_W+4 bits,
//     no underflow wrap. Registered; updates the cycle after level changes. Compare uses
//     counter >= period-1, so a shortened period never skips a tick: fires next cycle.
//   - food_eaten counted only in RUN. On the pulse completing FOODS_PER_LEVEL, food count
//     -> 0 and level+1, saturating at MAX_LEVEL (food count still wraps at saturation).
//   - food_eaten coincident with move-counter wrap: both take effect, that tick unaffected.
//   - refresh_tick: independent divider, 1 cycle high every REFRESH_DIV cycles from reset,
//     in all states.
//   - rst_n low mid-game: immediate return to reset values; no tick emitted.
// CONFIGURATION
//   SNAKE_TURBO_EN defined: extra input port `turbo` (1 bit). While turbo=1 in RUN, the
//     effective period is period>>1. Period changes follow the same >= compare rule.
//   SNAKE_TURBO_EN undefined: port `turbo` absent; period as above.
// TESTING (BASE_PERIOD=10 PERIOD_STEP=2 MIN_PERIOD=4 FOODS_PER_LEVEL=2 REFRESH_DIV=5)
//   1. Reset, start pulse -> state=1; move_tick at +10,+20,+30 cycles; level=0; no tick in IDLE.
//   2. 2 food pulses in RUN -> level=1, next ticks 8 apart; 6 more -> level=4, ticks 4 apart
//      (clamped); 30 more -> level saturates at 15, ticks still 4 apart.
//   3. pause_req 3 cycles after a tick -> no tick for 20 held cycles; pause_req -> next
//      tick exactly 7 cycles later.
//   4. game_over and pause_req same cycle in RUN -> state=3, no move_tick for 50 cycles,
//      level held; start -> state=1, level=0, tick at +10.
//   5. refresh_tick every 5 cycles from reset through IDLE/RUN/PAUSED/OVER; rst_n low
//      mid-RUN -> state=0, level=0, ticks 0 immediately, without a clk edge.
//   6. SNAKE_TURBO_EN, level 0, turbo=1 -> ticks 5 apart; turbo=0 -> 10 apart.

Source files
------------

// File: rtl/snake_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snake_tick_scheduler
// Description : Central timing controller for the Snake game. Sequences play
//               (IDLE/RUN/PAUSED/OVER) and produces single-cycle enable
//               strobes in the clk domain: a level-dependent move_tick and a
//               free-running refresh_tick for the display scan.
//               Optional feature macro: SNAKE_TURBO_EN adds a `turbo` input
//               that halves the effective move period while running.
//               rst_n asserts asynchronously; its deassertion is expected to
//               be synchronised to clk by the system reset generator.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_tick_scheduler #(
   parameter int unsigned BASE_PERIOD     = 50_000_000,
   parameter int unsigned PERIOD_STEP     = 2_500_000,
   parameter int unsigned MIN_PERIOD      = 10_000_000,
   parameter int unsigned FOODS_PER_LEVEL = 4,
   parameter int unsigned MAX_LEVEL       = 15,
   parameter int unsigned REFRESH_DIV     = 5000,
   parameter int unsigned CNT_W           = 32
) (
   input  logic       clk,
   input  logic       rst_n,
`ifdef SNAKE_TURBO_EN
   input  logic       turbo,
`endif
   input  logic       start,
   input  logic       pause_req,
   input  logic       game_over,
   input  logic       food_eaten,
   output logic       move_tick,
   output logic       refresh_tick,
   output logic [3:0] level,
   output logic [1:0] state
);

   // Period arithmetic is four bits wider than the counters so that
   // level*PERIOD_STEP can never wrap before the floor is applied.
   localparam int unsigned PW = CNT_W + 4;

   localparam logic [PW-1:0]    C_BASE      = PW'(BASE_PERIOD);
   localparam logic [PW-1:0]    C_STEP      = PW'(PERIOD_STEP);
   localparam logic [PW-1:0]    C_MIN       = PW'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] C_FOOD_LAST = CNT_W'(FOODS_PER_LEVEL - 1);
   localparam logic [CNT_W-1:0] C_REF_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [3:0]       C_MAX_LVL   = 4'(MAX_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   state_t           state_q,        state_d;
   logic [CNT_W-1:0] move_cnt_q,     move_cnt_d;
   logic [CNT_W-1:0] food_cnt_q,     food_cnt_d;
   logic [CNT_W-1:0] refresh_cnt_q,  refresh_cnt_d;
   logic [3:0]       level_q,        level_d;
   logic [PW-1:0]    period_q,       period_d;
   logic             move_tick_q,    move_tick_d;
   logic             refresh_tick_q, refresh_tick_d;

   logic [PW-1:0]    period_reduce;
   logic [PW-1:0]    eff_period;
   logic             move_wrap;
   logic             refresh_wrap;

   // Turbo halves the period only while running; elsewhere the counter is idle.
`ifdef SNAKE_TURBO_EN
   assign eff_period = (turbo && (state_q == ST_RUN)) ? (period_q >> 1) : period_q;
`else
   assign eff_period = period_q;
`endif

   // ">=" rather than "==": a period that shrinks below the current count
   // fires on the next cycle instead of running the counter all the way round.
   assign move_wrap = (PW'(move_cnt_q) >= (eff_period - PW'(1)));

   // Move period from level, floored at MIN_PERIOD without underflow.
   always_comb begin
      period_reduce = PW'(level_q) * C_STEP;
      if ((C_BASE > period_reduce) && ((C_BASE - period_reduce) > C_MIN)) begin
         period_d = C_BASE - period_reduce;
      end else begin
         period_d = C_MIN;
      end
   end

   // Display refresh divider, running in every game state.
   always_comb begin
      refresh_wrap   = (refresh_cnt_q >= C_REF_LAST);
      refresh_cnt_d  = refresh_wrap ? '0 : refresh_cnt_q + CNT_W'(1);
      refresh_tick_d = refresh_wrap;
   end

   // Game state sequencing, move counter, food counter and level.
   always_comb begin
      state_d     = state_q;
      move_cnt_d  = move_cnt_q;
      food_cnt_d  = food_cnt_q;
      level_d     = level_q;
      move_tick_d = 1'b0;

      case (state_q)
         // Strict priority: a higher-priority pulse that has no meaning in
         // this state still masks a coincident start.
         ST_IDLE, ST_OVER: begin
            if (!game_over && !pause_req && start) begin
               state_d    = ST_RUN;
               move_cnt_d = '0;
               food_cnt_d = '0;
               level_d    = '0;
            end
         end

         ST_RUN: begin
            move_cnt_d = move_wrap ? '0 : move_cnt_q + CNT_W'(1);
            // A period completing on the collision edge is not delivered.
            move_tick_d = move_wrap && !game_over;

            if (food_eaten) begin
               if (food_cnt_q >= C_FOOD_LAST) begin
                  food_cnt_d = '0;
                  if (level_q < C_MAX_LVL) begin
                     level_d = level_q + 4'd1;
                  end
               end else begin
                  food_cnt_d = food_cnt_q + CNT_W'(1);
               end
            end

            if (game_over) begin
               state_d = ST_OVER;
            end else if (pause_req) begin
               state_d = ST_PAUSED;
            end
         end

         ST_PAUSED: begin
            if (game_over) begin
               state_d = ST_OVER;
            end else if (pause_req) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         move_cnt_q     <= '0;
         food_cnt_q     <= '0;
         refresh_cnt_q  <= '0;
         level_q        <= '0;
         period_q       <= C_BASE;
         move_tick_q    <= 1'b0;
         refresh_tick_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         move_cnt_q     <= move_cnt_d;
         food_cnt_q     <= food_cnt_d;
         refresh_cnt_q  <= refresh_cnt_d;
         level_q        <= level_d;
         period_q       <= period_d;
         move_tick_q    <= move_tick_d;
         refresh_tick_q <= refresh_tick_d;
      end
   end

   assign move_tick    = move_tick_q;
   assign refresh_tick = refresh_tick_q;
   assign level        = level_q;
   assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_tick_scheduler
// Description : Scoreboard bench for snake_tick_scheduler. Stimulus pushes
//               the cycle number at which each move_tick is due; a monitor
//               pops on every observed move_tick. A refresh model runs
//               alongside. Turbo checks are built when SNAKE_TURBO_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_tick_scheduler;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       pause_req;
   logic       game_over;
   logic       food_eaten;
   logic       move_tick;
   logic       refresh_tick;
   logic [3:0] level;
   logic [1:0] state;
`ifdef SNAKE_TURBO_EN
   logic       turbo;
`endif

   int checks = 0;
   int errors = 0;
   int cyc;
   bit ref_en = 1'b0;
   int exp_ticks[$];
   int t;

   snake_tick_scheduler #(
      .BASE_PERIOD    (10),
      .PERIOD_STEP    (2),
      .MIN_PERIOD     (4),
      .FOODS_PER_LEVEL(2),
      .MAX_LEVEL      (15),
      .REFRESH_DIV    (5),
      .CNT_W          (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
`ifdef SNAKE_TURBO_EN
      .turbo       (turbo),
`endif
      .start       (start),
      .pause_req   (pause_req),
      .game_over   (game_over),
      .food_eaten  (food_eaten),
      .move_tick   (move_tick),
      .refresh_tick(refresh_tick),
      .level       (level),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number = clk edges since reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Move-tick monitor: every observed strobe must match the oldest expectation.
   always @(negedge clk) begin
      if (move_tick === 1'b1) begin
         checks++;
         if (exp_ticks.size() == 0) begin
            errors++;
            $display("FAIL move_tick: unexpected tick at cycle %0d, none expected", cyc);
         end else begin
            t = exp_ticks.pop_front();
            if (t != cyc) begin
               errors++;
               $display("FAIL move_tick: tick at cycle %0d, expected cycle %0d", cyc, t);
            end
         end
      end
   end

   // Refresh monitor: one-cycle strobe on every fifth edge after reset.
   always @(negedge clk) begin
      if (ref_en) begin
         checks++;
         if (refresh_tick !== ((cyc > 0) && (cyc % 5 == 0))) begin
            errors++;
            $display("FAIL refresh_tick: got %b at cycle %0d, expected %b",
                     refresh_tick, cyc, ((cyc > 0) && (cyc % 5 == 0)));
         end
      end
   end

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Expected ticks must all have been seen; sampled just after the monitor.
   task automatic check_pending(input string name);
      #1;
      check(name, exp_ticks.size(), 0);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_food(input int n);
      food_eaten = 1'b1;
      repeat (n) @(negedge clk);
      food_eaten = 1'b0;
   endtask

   task automatic push_ticks(input int first, input int spacing, input int count);
      for (int i = 0; i < count; i++) exp_ticks.push_back(first + i * spacing);
   endtask

   initial begin
      int a, tt, u, w, b, r, x;
      rst_n = 1'b0; start = 1'b0; pause_req = 1'b0; game_over = 1'b0; food_eaten = 1'b0;
`ifdef SNAKE_TURBO_EN
      turbo = 1'b0;
`endif
      step(3);
      check("reset_state", state, 0);
      check("reset_level", level, 0);
      check("reset_move_tick", move_tick, 0);
      rst_n = 1'b1;
      ref_en = 1'b1;

      // Idle: no ticks, then start.
      step(7);
      check("idle_state", state, 0);
      pulse_start();
      a = cyc;
      check("run_state", state, 1);
      check("run_level0", level, 0);
      push_ticks(a + 10, 10, 3);
      step(30);
      check_pending("level0_ticks");

      // Two foods -> level 1, period 8.
      tt = cyc;
      pulse_food(2);
      check("level1", level, 1);
      push_ticks(tt + 8, 8, 2);
      step(14);
      check_pending("level1_ticks");

      // Six foods -> level 4, period clamped at 4; shortened period fires early.
      u = cyc;
      push_ticks(u + 6, 4, 4);
      pulse_food(6);
      check("level4", level, 4);
      step(12);
      check_pending("level4_ticks");

      // Thirty foods -> level saturates at 15, period stays 4.
      u = cyc;
      push_ticks(u + 4, 4, 8);
      pulse_food(30);
      check("level_sat", level, 15);
      step(2);
      check_pending("sat_ticks");

      // game_over with pause_req -> OVER, no ticks, level held.
      step(1);
      w = cyc;
      game_over = 1'b1; pause_req = 1'b1;
      @(negedge clk);
      game_over = 1'b0; pause_req = 1'b0;
      check("over_state", state, 3);
      check("over_level", level, 15);
      step(50);
      check("over_state_held", state, 3);
      check("over_level_held", level, 15);
      pulse_start();
      b = cyc;
      check("restart_state", state, 1);
      check("restart_level", level, 0);
      push_ticks(b + 10, 10, 2);
      step(20);
      check_pending("restart_ticks");

      // Pause three cycles after a tick, hold, start ignored, resume.
      step(2);
      pause_req = 1'b1;
      @(negedge clk);
      pause_req = 1'b0;
      check("paused_state", state, 2);
      step(5);
      pulse_start();
      check("paused_start_ignored", state, 2);
      step(14);
      pause_req = 1'b1;
      @(negedge clk);
      pause_req = 1'b0;
      r = cyc;
      check("resume_state", state, 1);
      push_ticks(r + 7, 10, 1);
      step(7);
      check_pending("resume_tick");

      // Level 1, then asynchronous reset while move_tick is high.
      x = cyc;
      push_ticks(x + 8, 8, 1);
      step(1);
      pulse_food(2);
      check("pre_reset_level", level, 1);
      step(5);
      ref_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async_state", state, 0);
      check("async_level", level, 0);
      check("async_move_tick", move_tick, 0);
      check("async_refresh_tick", refresh_tick, 0);
      step(3);
      rst_n = 1'b1;
      ref_en = 1'b1;
      step(12);
      check("post_reset_state", state, 0);
      check_pending("post_reset_ticks");

`ifdef SNAKE_TURBO_EN
      // Turbo halves the period; releasing it restores the full period.
      @(negedge clk);
      turbo = 1'b1;
      pulse_start();
      b = cyc;
      push_ticks(b + 5, 5, 2);
      push_ticks(b + 20, 10, 1);
      step(10);
      turbo = 1'b0;
      step(10);
      check_pending("turbo_ticks");
`endif

      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
